// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDone  = 2'd2,
        StFault = 2'd3
    } fetch_state_e;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch/stall event counters; instantiated only when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_inc_i,
    input  logic        stall_inc_i,
    output logic [31:0] fetch_count_o,
    output logic [31:0] stall_count_o
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_o <= '0;
            stall_count_o <= '0;
        end else begin
            if (fetch_inc_i && (fetch_count_o != '1)) begin
                fetch_count_o <= fetch_count_o + 32'd1;
            end
            if (stall_inc_i && (stall_count_o != '1)) begin
                stall_count_o <= stall_count_o + 32'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the ROM address and hands instructions to decode.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    output logic [DATA_WIDTH-1:0] rom_address_o,
    input  logic [DATA_WIDTH-1:0] rom_instruction_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  done_o,
`ifdef FETCH_PERF_CNT_EN
    output logic                  fault_o,
    output logic [31:0]           fetch_count_o,
    output logic [31:0]           stall_count_o
`else
    output logic                  fault_o
`endif
);

    localparam logic [DATA_WIDTH-1:0] ROM_BYTES  = DATA_WIDTH'(WORD_BYTES * MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(WORD_BYTES);

    fetch_state_e          state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  slot_free;
    logic                  in_range;
    logic                  misaligned;
    logic                  capture;

    assign rom_address_o = pc_q;
    assign slot_free     = !instr_valid_o || instr_ready_i;
    // Offset compare wraps modulo 2^DATA_WIDTH, so PCs below RESET_PC are out of range too.
    assign in_range      = (pc_q - RESET_PC) < ROM_BYTES;
    assign misaligned    = redirect_pc_i[1:0] != 2'b00;
    assign capture       = (state_q == StRun) && !redirect_i && slot_free && in_range;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            instr_o       <= '0;
            instr_pc_o    <= '0;
            instr_valid_o <= 1'b0;
            done_o        <= 1'b0;
            fault_o       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (redirect_i) begin
                        // Flush wins over any handshake in the same cycle.
                        instr_valid_o <= 1'b0;
                        if (misaligned) begin
                            state_q <= StFault;
                            fault_o <= 1'b1;
                        end else begin
                            pc_q <= redirect_pc_i;
                        end
                    end else if (capture) begin
                        instr_o       <= rom_instruction_i;
                        instr_pc_o    <= pc_q;
                        instr_valid_o <= 1'b1;
                        pc_q          <= pc_q + PC_STEP;
                    end else if (slot_free) begin
                        state_q       <= StDone;
                        done_o        <= 1'b1;
                        instr_valid_o <= 1'b0;
                    end
                end
                StDone, StFault: begin
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall;

    assign stall = (state_q == StRun) && instr_valid_o && !instr_ready_i;

    fetch_perf_counters u_perf (
        .clk           (clk),
        .reset         (reset),
        .fetch_inc_i   (capture),
        .stall_inc_i   (stall),
        .fetch_count_o (fetch_count_o),
        .stall_count_o (stall_count_o)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a 32-word ROM holding 0x1000+k.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [31:0] rom_address_o;
    logic [31:0] rom_instruction_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        done_o;
    logic        fault_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_o;
    logic [31:0] stall_count_o;
`endif

    int total;
    int bad;

    logic [31:0] rom [0:31];

    assign rom_instruction_i = (rom_address_o < 32'h80) ? rom[rom_address_o[6:2]] : 32'h0;

    fetch_sequencer #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (32),
        .RESET_PC     (32'h0)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start_i           (start_i),
        .rom_address_o     (rom_address_o),
        .rom_instruction_i (rom_instruction_i),
        .instr_o           (instr_o),
        .instr_pc_o        (instr_pc_o),
        .instr_valid_o     (instr_valid_o),
        .instr_ready_i     (instr_ready_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .done_o            (done_o),
`ifdef FETCH_PERF_CNT_EN
        .fault_o           (fault_o),
        .fetch_count_o     (fetch_count_o),
        .stall_count_o     (stall_count_o)
`else
        .fault_o           (fault_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset         = 1'b0;
        start_i       = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (rom_address_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=%h", rom_address_o, 32'h0); end
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_valid_o); end
        total++; if (instr_o !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr_o); end
        total++; if (instr_pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", instr_pc_o); end
        total++; if ({done_o, fault_o} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {done_o, fault_o}); end
        tick();
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", instr_valid_o); end
    endtask

    // Leaves the DUT with instr_pc_o=0x8 valid.
    task automatic test_linear();
        start_i       = 1'b1;
        instr_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL lin_cycle1_valid got=%b want=0", instr_valid_o); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (instr_valid_o !== 1'b1) begin bad++; $display("FAIL lin_valid[%0d] got=%b want=1", k, instr_valid_o); end
            total++; if (instr_o !== 32'h1000 + k) begin bad++; $display("FAIL lin_instr[%0d] got=%h want=%h", k, instr_o, 32'h1000 + k); end
            total++; if (instr_pc_o !== 32'(4 * k)) begin bad++; $display("FAIL lin_pc[%0d] got=%h want=%h", k, instr_pc_o, 32'(4 * k)); end
        end
    endtask

    task automatic test_backpressure();
        instr_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (instr_o !== 32'h1002 || instr_pc_o !== 32'h8 || instr_valid_o !== 1'b1)
                begin bad++; $display("FAIL bp_hold[%0d] got=%h/%h/%b want=1002/8/1", k, instr_o, instr_pc_o, instr_valid_o); end
            total++; if (rom_address_o !== 32'hC) begin bad++; $display("FAIL bp_addr[%0d] got=%h want=c", k, rom_address_o); end
        end
        instr_ready_i = 1'b1;
        tick();
        total++; if (instr_o !== 32'h1003 || instr_pc_o !== 32'hC)
            begin bad++; $display("FAIL bp_resume got=%h/%h want=1003/c", instr_o, instr_pc_o); end
        tick();
        total++; if (instr_pc_o !== 32'h10) begin bad++; $display("FAIL pre_redirect_pc got=%h want=10", instr_pc_o); end
    endtask

    task automatic test_redirect();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%b want=0", instr_valid_o); end
        total++; if (rom_address_o !== 32'h40) begin bad++; $display("FAIL redir_addr got=%h want=40", rom_address_o); end
        tick();
        total++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h40 || instr_o !== 32'h1010)
            begin bad++; $display("FAIL redir_target got=%b/%h/%h want=1/40/1010", instr_valid_o, instr_pc_o, instr_o); end
    endtask

    task automatic test_end_of_rom();
        for (int k = 17; k < 32; k++) begin
            tick();
            total++; if (instr_pc_o !== 32'(4 * k) || instr_o !== 32'h1000 + k)
                begin bad++; $display("FAIL end_seq[%0d] got=%h/%h want=%h/%h", k, instr_pc_o, instr_o, 32'(4 * k), 32'h1000 + k); end
        end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL end_early_done got=%b want=0", done_o); end
        tick();
        total++; if (done_o !== 1'b1 || instr_valid_o !== 1'b0)
            begin bad++; $display("FAIL end_done got=%b/%b want=1/0", done_o, instr_valid_o); end
        total++; if (rom_address_o !== 32'h80) begin bad++; $display("FAIL end_addr got=%h want=80", rom_address_o); end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0;
        tick();
        tick();
        redirect_i = 1'b0;
        total++; if (rom_address_o !== 32'h80 || done_o !== 1'b1 || instr_valid_o !== 1'b0)
            begin bad++; $display("FAIL end_sticky got=%h/%b/%b want=80/1/0", rom_address_o, done_o, instr_valid_o); end
    endtask

    task automatic test_redirect_out_of_range();
        apply_reset();
        start_i       = 1'b1;
        instr_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        total++; if (done_o !== 1'b0 || rom_address_o !== 32'h100)
            begin bad++; $display("FAIL oor_redir got=%b/%h want=0/100", done_o, rom_address_o); end
        tick();
        total++; if (done_o !== 1'b1 || instr_valid_o !== 1'b0)
            begin bad++; $display("FAIL oor_done got=%b/%b want=1/0", done_o, instr_valid_o); end
    endtask

    task automatic test_fault();
        apply_reset();
        start_i       = 1'b1;
        instr_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h22;
        tick();
        redirect_i = 1'b0;
        total++; if (fault_o !== 1'b1 || instr_valid_o !== 1'b0)
            begin bad++; $display("FAIL fault_set got=%b/%b want=1/0", fault_o, instr_valid_o); end
        total++; if (rom_address_o !== 32'h4) begin bad++; $display("FAIL fault_pc got=%h want=4", rom_address_o); end
        start_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        tick();
        start_i    = 1'b0;
        redirect_i = 1'b0;
        total++; if (fault_o !== 1'b1 || rom_address_o !== 32'h4 || instr_valid_o !== 1'b0)
            begin bad++; $display("FAIL fault_sticky got=%b/%h/%b want=1/4/0", fault_o, rom_address_o, instr_valid_o); end
        #3;
        reset = 1'b0;
        #1;
        total++; if (fault_o !== 1'b0 || rom_address_o !== 32'h0 || instr_o !== 32'h0)
            begin bad++; $display("FAIL async_reset got=%b/%h/%h want=0/0/0", fault_o, rom_address_o, instr_o); end
        #1;
        reset = 1'b1;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_counters();
        apply_reset();
        total++; if (fetch_count_o !== 32'd0 || stall_count_o !== 32'd0)
            begin bad++; $display("FAIL perf_reset got=%0d/%0d want=0/0", fetch_count_o, stall_count_o); end
        start_i       = 1'b1;
        instr_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        instr_ready_i = 1'b0;
        tick();
        tick();
        instr_ready_i = 1'b1;
        tick();
        tick();
        tick();
        total++; if (fetch_count_o !== 32'd5) begin bad++; $display("FAIL perf_fetch got=%0d want=5", fetch_count_o); end
        total++; if (stall_count_o !== 32'd2) begin bad++; $display("FAIL perf_stall got=%0d want=2", stall_count_o); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        for (int k = 0; k < 32; k++) begin
            rom[k] = 32'h1000 + k;
        end
        test_reset();
        test_linear();
        test_backpressure();
        test_redirect();
        test_end_of_rom();
        test_redirect_out_of_range();
        test_fault();
`ifdef FETCH_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
